// File: rtl/sdac_deser_multi_if.sv
// Serial-in / parallel-out bundle for the multi-channel SDAC front end.
// The stimulus side drives en/soc/si; the deserialiser drives the rest.
interface sdac_deser_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) ();
  logic                      en;
  logic                      soc;
  logic                      si;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       ch_valid;
  logic                      frame_done;
  logic                      frame_err;
  logic                      busy;

  modport master (
    output en, soc, si,
    input  dout, ch_valid, frame_done, frame_err, busy
  );

  modport slave (
    input  en, soc, si,
    output dout, ch_valid, frame_done, frame_err, busy
  );
endinterface

// File: rtl/sdac_deser_multi.sv
// Framed serial deserialiser: one soc-framed bitstream into CHANNELS codes,
// with selectable bit order and per-channel or whole-frame output update.
module sdac_deser_multi #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int MSB_FIRST = 1,
  parameter int LOAD_MODE = 1
) (
  input logic               clk,
  input logic               rst_n,
  sdac_deser_multi_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = CHANNELS * WIDTH;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t            state_q, state_d;
  logic              soc_q, soc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [WIDTH-1:0]  sh_q, sh_d, sh_in;
  logic [WIDTH-1:0]  shadow_q [CHANNELS];
  logic [WIDTH-1:0]  shadow_d [CHANNELS];
  logic              pend_q, pend_d;
  logic [CW-1:0]     pidx_q, pidx_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic [CHANNELS-1:0] chv_q, chv_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    if (MSB_FIRST != 0) sh_in = {sh_q[WIDTH-2:0], bus.si};
    else                sh_in = {bus.si, sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    soc_d    = bus.soc;
    bit_d    = bit_q;
    ch_d     = ch_q;
    sh_d     = sh_q;
    shadow_d = shadow_q;
    pend_d   = 1'b0;
    pidx_d   = pidx_q;
    dout_d   = dout_q;
    chv_d    = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // A channel finished last cycle lands in dout even if this cycle aborts.
    if (pend_q) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (pidx_q == CW'(c)) begin
          dout_d[c*WIDTH +: WIDTH] = shadow_q[c];
          chv_d[c] = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.soc && !soc_q) begin
          state_d = SHIFT;
          bit_d   = '0;
          ch_d    = '0;
        end
      end
      SHIFT: begin
        if (!bus.soc) begin
          err_d   = 1'b1;
          state_d = IDLE;
          bit_d   = '0;
          ch_d    = '0;
          sh_d    = '0;
        end else if (bus.en) begin
          sh_d = sh_in;
          if (bit_q == LAST_BIT) begin
            shadow_d[ch_q] = sh_in;
            bit_d  = '0;
            ch_d   = ch_q + 1'b1;
            pidx_d = ch_q;
            if (ch_q == LAST_CH) state_d = LOAD;
            else pend_d = (LOAD_MODE == 0);
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ch_d    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
          if (LOAD_MODE != 0 || c == CHANNELS - 1) begin
            dout_d[c*WIDTH +: WIDTH] = shadow_q[c];
            chv_d[c] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      soc_q    <= 1'b0;
      bit_q    <= '0;
      ch_q     <= '0;
      sh_q     <= '0;
      shadow_q <= '{default: '0};
      pend_q   <= 1'b0;
      pidx_q   <= '0;
      dout_q   <= '0;
      chv_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      soc_q    <= soc_d;
      bit_q    <= bit_d;
      ch_q     <= ch_d;
      sh_q     <= sh_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pidx_q   <= pidx_d;
      dout_q   <= dout_d;
      chv_q    <= chv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.ch_valid   = chv_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_sdac_deser_multi.sv
// Bench for sdac_deser_multi: three instances (MSB/LSB-first, frame and
// per-channel load) fed the same framing, checked against a queue model.
module tb_sdac_deser_multi;
  logic clk;
  logic rst_n;
  logic soc;
  logic en;
  logic si_m;
  logic si_l;

  int checks;
  int errors;

  logic [15:0] last_ab;
  logic [15:0] dout_c_m;
  logic [15:0] q_ab [$];
  logic [17:0] q_c [$];
  logic [15:0] mon_exp;
  logic [17:0] mon_exp_c;

  sdac_deser_multi_if #(.WIDTH(8), .CHANNELS(2)) ifa ();
  sdac_deser_multi_if #(.WIDTH(8), .CHANNELS(2)) ifb ();
  sdac_deser_multi_if #(.WIDTH(8), .CHANNELS(2)) ifc ();

  assign ifa.soc = soc;
  assign ifa.en  = en;
  assign ifa.si  = si_m;
  assign ifb.soc = soc;
  assign ifb.en  = en;
  assign ifb.si  = si_l;
  assign ifc.soc = soc;
  assign ifc.en  = en;
  assign ifc.si  = si_m;

  sdac_deser_multi #(
    .WIDTH(8), .CHANNELS(2), .MSB_FIRST(1), .LOAD_MODE(1)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  sdac_deser_multi #(
    .WIDTH(8), .CHANNELS(2), .MSB_FIRST(0), .LOAD_MODE(1)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  sdac_deser_multi #(
    .WIDTH(8), .CHANNELS(2), .MSB_FIRST(1), .LOAD_MODE(0)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard side: pop an expectation whenever a DUT publishes data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.frame_done === 1'b1) begin
        checks++;
        if (q_ab.size() == 0) begin
          errors++;
          $display("FAIL sb_ab_unexpected got frame_done=1 exp none");
        end else begin
          mon_exp = q_ab.pop_front();
          checks++;
          if (ifa.dout !== mon_exp) begin
            errors++;
            $display("FAIL sb_a_dout got %h exp %h", ifa.dout, mon_exp);
          end
          checks++;
          if (ifb.dout !== mon_exp) begin
            errors++;
            $display("FAIL sb_b_dout got %h exp %h", ifb.dout, mon_exp);
          end
        end
      end
      if (ifc.ch_valid !== 2'b00) begin
        checks++;
        if (q_c.size() == 0) begin
          errors++;
          $display("FAIL sb_c_unexpected got ch_valid=%b exp none",
                   ifc.ch_valid);
        end else begin
          mon_exp_c = q_c.pop_front();
          checks++;
          if ({ifc.ch_valid, ifc.dout} !== mon_exp_c) begin
            errors++;
            $display("FAIL sb_c got chv=%b dout=%h exp chv=%b dout=%h",
                     ifc.ch_valid, ifc.dout,
                     mon_exp_c[17:16], mon_exp_c[15:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic [15:0] code, input int k);
    int ch;
    int b;
    ch   = k / 8;
    b    = k % 8;
    si_m = code[ch*8 + 7 - b];
    si_l = code[ch*8 + b];
    en   = 1'b1;
  endtask

  task automatic do_frame(input logic [15:0] code, input bit gap,
                          input bit after_rst, output int busy_cycles);
    busy_cycles = 0;
    q_ab.push_back(code);
    q_c.push_back({2'b01, dout_c_m[15:8], code[7:0]});
    q_c.push_back({2'b10, code});
    dout_c_m = code;
    if (!after_rst) begin
      soc = 1'b0;
      en  = 1'b0;
      tick();
    end
    soc = 1'b1;
    en  = 1'b0;
    tick();
    if (ifa.busy === 1'b1) busy_cycles++;
    for (int k = 0; k < 16; k++) begin
      if (gap) begin
        en   = 1'b0;
        si_m = 1'($urandom_range(0, 1));
        si_l = 1'($urandom_range(0, 1));
        tick();
        if (ifa.busy === 1'b1) busy_cycles++;
      end
      drive_bit(code, k);
      tick();
      if (ifa.busy === 1'b1) busy_cycles++;
    end
    en = 1'b0;
    tick();
    checks++;
    if ({ifa.frame_done, ifb.frame_done, ifc.frame_done} !== 3'b111) begin
      errors++;
      $display("FAIL frame_done got %b exp 111",
               {ifa.frame_done, ifb.frame_done, ifc.frame_done});
    end
    checks++;
    if (ifa.ch_valid !== 2'b11 || ifb.ch_valid !== 2'b11) begin
      errors++;
      $display("FAIL chv_frame got %b/%b exp 11/11",
               ifa.ch_valid, ifb.ch_valid);
    end
    checks++;
    if (ifa.dout !== code) begin
      errors++;
      $display("FAIL dout_at_done got %h exp %h", ifa.dout, code);
    end
    last_ab = code;
    tick();
    checks++;
    if ({ifa.frame_done, ifa.busy, ifc.busy} !== 3'b000) begin
      errors++;
      $display("FAIL post_done got done/busy/busy %b exp 000",
               {ifa.frame_done, ifa.busy, ifc.busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    soc   = 1'b0;
    en    = 1'b0;
    si_m  = 1'b0;
    si_l  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ifa.dout, ifb.dout, ifc.dout} !== 48'h0) begin
      errors++;
      $display("FAIL reset_dout got %h exp 0", {ifa.dout, ifb.dout, ifc.dout});
    end
    checks++;
    if ({ifa.ch_valid, ifa.frame_done, ifa.frame_err, ifa.busy,
         ifc.ch_valid, ifc.busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got nonzero exp 0");
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b exp 0", ifa.busy);
    end
  endtask

  task automatic test_basic();
    int bc;
    do_frame(16'h3CA5, 1'b0, 1'b0, bc);
    checks++;
    if (bc != 17) begin
      errors++;
      $display("FAIL busy_len got %0d exp 17", bc);
    end
  endtask

  task automatic test_rearm();
    int seen;
    seen = 0;
    soc  = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      si_m = 1'($urandom_range(0, 1));
      si_l = si_m;
      tick();
      if (ifa.busy === 1'b1 || ifc.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rearm_no_restart got busy %0d cycles exp 0", seen);
    end
    en = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] code;
    code = 16'h6699;
    q_c.push_back({2'b01, dout_c_m[15:8], code[7:0]});
    dout_c_m[7:0] = code[7:0];
    soc = 1'b0;
    tick();
    soc = 1'b1;
    tick();
    for (int k = 0; k < 11; k++) begin
      drive_bit(code, k);
      tick();
    end
    soc = 1'b0;
    en  = 1'b1;
    tick();
    checks++;
    if ({ifa.frame_err, ifb.frame_err, ifc.frame_err} !== 3'b111) begin
      errors++;
      $display("FAIL abort_err got %b exp 111",
               {ifa.frame_err, ifb.frame_err, ifc.frame_err});
    end
    checks++;
    if ({ifa.busy, ifb.busy, ifc.busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_busy got %b exp 000",
               {ifa.busy, ifb.busy, ifc.busy});
    end
    checks++;
    if (ifa.dout !== last_ab || ifb.dout !== last_ab) begin
      errors++;
      $display("FAIL abort_hold got %h/%h exp %h",
               ifa.dout, ifb.dout, last_ab);
    end
    checks++;
    if (ifc.dout !== dout_c_m || ifc.ch_valid !== 2'b00) begin
      errors++;
      $display("FAIL abort_partial got %h chv=%b exp %h chv=00",
               ifc.dout, ifc.ch_valid, dout_c_m);
    end
    en = 1'b0;
    tick();
    checks++;
    if (ifa.frame_err !== 1'b0 || ifa.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse got err=%b done=%b exp 0 0",
               ifa.frame_err, ifa.frame_done);
    end
  endtask

  task automatic test_patterns();
    int bc;
    logic [15:0] pats [3];
    pats[0] = 16'h0000;
    pats[1] = 16'hFFFF;
    pats[2] = 16'h0F0F;
    for (int i = 0; i < 3; i++) do_frame(pats[i], 1'b0, 1'b0, bc);
  endtask

  task automatic test_gap();
    int bc;
    do_frame(16'h3CA5, 1'b1, 1'b0, bc);
    checks++;
    if (bc != 33) begin
      errors++;
      $display("FAIL gap_busy_len got %0d exp 33", bc);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    for (int i = 0; i < 4; i++) do_frame(16'($urandom), 1'b0, 1'b0, bc);
  endtask

  task automatic test_reset_mid();
    int bc;
    logic [15:0] code;
    code = 16'hC381;
    soc  = 1'b0;
    tick();
    soc = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      drive_bit(code, k);
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.dout, ifb.dout, ifc.dout} !== 48'h0) begin
      errors++;
      $display("FAIL mid_reset_dout got %h exp 0",
               {ifa.dout, ifb.dout, ifc.dout});
    end
    checks++;
    if ({ifa.busy, ifb.busy, ifc.busy, ifa.frame_err,
         ifc.ch_valid} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_flags got nonzero exp 0");
    end
    last_ab  = 16'h0;
    dout_c_m = 16'h0;
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    do_frame(16'h5AC3, 1'b0, 1'b1, bc);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_ab  = 16'h0;
    dout_c_m = 16'h0;
    test_reset();
    test_basic();
    test_rearm();
    test_abort();
    test_patterns();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (q_ab.size() != 0 || q_c.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d/%0d exp 0/0",
               q_ab.size(), q_c.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdac_deser_multi.md
Name: sdac_deser_multi

Overview:
- Parametrised serial-input DAC front end; next generation of the single-channel SDAC.
- Deserialises one framed serial bitstream (si, gated by en, framed by soc) into CHANNELS parallel codes of WIDTH bits each.
- Supports configurable bit order and per-channel or simultaneous output update.
- Sits between the serial stimulus or sine-sample source and the per-channel DAC/analog models, which consume dout.

Parameters:
- WIDTH, 8: bits per channel code (2..16).
- CHANNELS, 2: channels per frame (1..8).
- MSB_FIRST, 1: 1 = first bit of each channel is its MSB; 0 = first bit is its LSB.
- LOAD_MODE, 1: 0 = each channel's dout slice updates as soon as that channel completes; 1 = all slices update together at frame end.

Ports:
- clk  in  1  system clock (100 MHz nominal); all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  bit-enable; si is sampled only when en=1.
- soc  in  1  start of conversion; a rising edge starts a frame, and soc must stay high for the whole frame.
- si  in  1  serial data.
- dout  out  CHANNELS*WIDTH  channel codes; channel c occupies bits [c*WIDTH +: WIDTH].
- ch_valid  out  CHANNELS  one-cycle pulse per channel slice update.
- frame_done  out  1  one-cycle pulse when a complete frame has been loaded.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high while a frame is in progress (SHIFT or LOAD).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; soc_q=0.
  - Shift register, bit and channel counters, and shadow registers cleared.
  - dout=0; ch_valid=0; frame_done=0; frame_err=0; busy=0.
- Edge detect: soc_q <= soc every cycle. A start is detected when soc=1 and soc_q=0. If soc is already high at reset release, a frame starts.
- State IDLE:
  - On start, go to SHIFT with bit_cnt=0 and ch_cnt=0.
  - si is not sampled in the detect cycle.
- State SHIFT:
  - en=1: shift si in, bit_cnt+1.
    - MSB_FIRST=1: left shift, si enters the LSB.
    - MSB_FIRST=0: right shift, si enters bit WIDTH-1.
  - en=0: hold all state.
  - Channel complete (bit_cnt=WIDTH-1 with en=1):
    - Assembled code goes to shadow[ch_cnt].
    - bit_cnt=0, ch_cnt+1.
    - LOAD_MODE=0: on the next edge, dout slice ch_cnt updates and ch_valid[ch_cnt] pulses.
  - Last channel complete (ch_cnt=CHANNELS-1): go to LOAD.
  - soc=0 in any SHIFT cycle (abort):
    - frame_err pulses on the next edge; go to IDLE.
    - Partial data is discarded.
    - LOAD_MODE=1: dout is unchanged.
    - LOAD_MODE=0: slices already completed in this frame keep their new values.
    - If the abort edge coincides with a channel-complete edge, abort wins: no update, no ch_valid.
- State LOAD (exactly one cycle):
  - LOAD_MODE=1: dout <= all shadows and ch_valid = all ones, updating on the edge that leaves LOAD.
  - frame_done pulses, coincident with the last ch_valid pulse.
  - Go to IDLE.
- Latency: last frame bit sampled at edge E → dout, ch_valid and frame_done valid after edge E+1, high for one cycle.
- Re-arm: the next frame requires soc low for at least 1 cycle, then high. soc staying high after frame_done does not restart.
- busy=1 in SHIFT and LOAD.
- Frame length: CHANNELS*WIDTH enabled bits.
- Counters: bit_cnt has clog2(WIDTH) bits, ch_cnt has clog2(CHANNELS) bits (minimum 1). Both wrap only via the explicit resets above.
- Reset mid-frame: immediate return to reset values; no pulses.

Test Plan:
- WIDTH=8, CHANNELS=2, MSB_FIRST=1, LOAD_MODE=1, en=1; soc rise, then bits 0xA5 then 0x3C MSB-first → dout=0x3CA5, ch_valid=2'b11 and frame_done one cycle after the 16th bit; busy high for 17 cycles.
- Same frame with en low every other cycle (32 cycles) → identical dout=0x3CA5; frame_done one cycle after the last enabled bit.
- MSB_FIRST=0, bits sent as 0xA5 then 0x3C LSB-first → dout=0x3CA5.
- LOAD_MODE=0: ch_valid[0] pulses one cycle after bit 8 with dout[7:0]=0xA5 and dout[15:8] still old; ch_valid[1] and frame_done pulse one cycle after bit 16.
- Abort: drop soc after 11 bits → frame_err one pulse, dout unchanged (LOAD_MODE=1), busy=0. Holding soc high after a completed frame → no new frame until soc goes low then high.
- Assert rst_n=0 mid-frame (bit 5) → all outputs 0 asynchronously. Release with soc=1 → new frame starts and completes normally.
